// File: rtl/note_pkg.sv
// Shared types, encodings and default geometry for the falling-note sequencer.
package note_pkg;
    localparam int Y_W          = 10;
    localparam int NUM_LANES    = 3;
    localparam int SPAWN_Y_DEF  = 0;
    localparam int HIT_Y_DEF    = 440;
    localparam int HIT_WIN_DEF  = 20;
    localparam int BOTTOM_Y_DEF = 479;

    localparam logic [1:0] LANE_R = 2'd0;
    localparam logic [1:0] LANE_G = 2'd1;
    localparam logic [1:0] LANE_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic           valid;
        logic [1:0]     lane;
        logic [Y_W-1:0] y;
    } slot_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        return (s > 32'd255) ? 8'hff : s[7:0];
    endfunction

    // Signed distance keeps the compare correct when y is above the hit line.
    function automatic logic in_window(input logic [Y_W-1:0] y, input int hit_y, input int win);
        logic signed [Y_W:0] d;
        logic signed [Y_W:0] w;
        d = $signed({1'b0, y}) - $signed((Y_W+1)'(hit_y));
        w = $signed((Y_W+1)'(win));
        return (d >= -w) && (d <= w);
    endfunction
endpackage

// File: rtl/note_slot_pick.sv
// Lowest-set-bit priority encoder: index of the first request and a found flag.
module note_slot_pick #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

    assign found = |req;
endmodule

// File: rtl/note_scheduler.sv
// Falling-note sequencer: pattern-driven spawning, slot motion, hit judging and miss tracking.
module note_scheduler
    import note_pkg::*;
#(
    parameter  int NUM_SLOTS = 8,
    parameter  int SPAWN_Y   = SPAWN_Y_DEF,
    parameter  int HIT_Y     = HIT_Y_DEF,
    parameter  int HIT_WIN   = HIT_WIN_DEF,
    parameter  int BOTTOM_Y  = BOTTOM_Y_DEF,
    parameter  int PAT_LEN   = 8,
    localparam int SW        = $clog2(NUM_SLOTS),
    localparam int PW        = $clog2(PAT_LEN)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           pause,
    input  logic           move_tick,
    input  logic           beat_tick,
    input  logic [2:0]     pat_data,
    output logic [PW-1:0]  pat_addr,
    input  logic [2:0]     hit_btn,
    input  logic [SW-1:0]  rd_idx,
    output logic           rd_valid,
    output logic [1:0]     rd_lane,
    output logic [Y_W-1:0] rd_y,
    output logic [7:0]     score,
    output logic [7:0]     miss_cnt,
    output logic           spawn_drop,
    output logic [1:0]     state,
    output logic           busy
);
    slot_t [NUM_SLOTS-1:0]                 slots;
    state_t                                st_q, st_d;
    logic [2:0]                            vld_pipe;  // one-hot lane phase: red, green, blue
    logic [2:0]                            pat_lat;
    logic                                  consumed;
    logic [NUM_SLOTS-1:0]                  valid_vec, hit_mask, retire_mask;
    logic [NUM_LANES-1:0][NUM_SLOTS-1:0]   hit_req;
    logic [NUM_LANES-1:0][SW-1:0]          hit_idx;
    logic [NUM_LANES-1:0]                  hit_found, hit_take;
    logic [SW-1:0]                         free_idx;
    logic                                  free_found;
    logic                                  spawn_req;
    logic [1:0]                            spawn_lane;
    int unsigned                           hit_cnt, retire_cnt;

    assign busy     = |vld_pipe;
    assign state    = st_q;
    assign rd_valid = slots[rd_idx].valid;
    assign rd_lane  = slots[rd_idx].lane;
    assign rd_y     = slots[rd_idx].y;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign valid_vec[s] = slots[s].valid;
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign hit_req[l][s] = slots[s].valid && (slots[s].lane == 2'(l))
                                   && in_window(slots[s].y, HIT_Y, HIT_WIN);
        end
    end

    // Free mask comes from the registered valids, so slots freed this cycle stay unused.
    note_slot_pick #(.N(NUM_SLOTS)) u_free (
        .req(~valid_vec), .idx(free_idx), .found(free_found)
    );

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_hit
        note_slot_pick #(.N(NUM_SLOTS)) u_hit (
            .req(hit_req[l]), .idx(hit_idx[l]), .found(hit_found[l])
        );
    end

    always_comb begin
        spawn_lane = LANE_R;
        spawn_req  = 1'b0;
        if (vld_pipe[0]) begin
            spawn_lane = LANE_R;
            spawn_req  = pat_lat[2];
        end else if (vld_pipe[1]) begin
            spawn_lane = LANE_G;
            spawn_req  = pat_lat[1];
        end else if (vld_pipe[2]) begin
            spawn_lane = LANE_B;
            spawn_req  = pat_lat[0];
        end
    end

    always_comb begin
        hit_mask    = '0;
        hit_take    = '0;
        hit_cnt     = 0;
        retire_mask = '0;
        retire_cnt  = 0;
        for (int l = 0; l < NUM_LANES; l++) begin
            hit_take[l] = hit_btn[NUM_LANES-1-l] && hit_found[l];
            if (hit_take[l]) begin
                hit_mask[hit_idx[l]] = 1'b1;
                hit_cnt = hit_cnt + 1;
            end
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (move_tick && slots[s].valid && !hit_mask[s] && (slots[s].y == Y_W'(BOTTOM_Y))) begin
                retire_mask[s] = 1'b1;
                retire_cnt = retire_cnt + 1;
            end
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:  if (start) st_d = ST_RUN;
            ST_RUN: begin
                if (pause && !busy)                          st_d = ST_PAUSE;
                else if (consumed && !(|valid_vec) && !busy) st_d = ST_DONE;
            end
            ST_PAUSE: if (!pause) st_d = ST_RUN;
            ST_DONE:  if (!start) st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) st_q <= ST_IDLE;
        else        st_q <= st_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slots      <= '0;
            vld_pipe   <= '0;
            pat_lat    <= '0;
            pat_addr   <= '0;
            consumed   <= 1'b0;
            score      <= '0;
            miss_cnt   <= '0;
            spawn_drop <= 1'b0;
        end else begin
            spawn_drop <= 1'b0;
            case (st_q)
                ST_IDLE: if (start) begin
                    slots    <= '0;
                    vld_pipe <= '0;
                    pat_addr <= '0;
                    consumed <= 1'b0;
                    score    <= '0;
                    miss_cnt <= '0;
                end
                ST_RUN: begin
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (hit_mask[s] || retire_mask[s])
                            slots[s].valid <= 1'b0;
                        else if (move_tick && slots[s].valid)
                            slots[s].y <= slots[s].y + 1'b1;
                    end
                    if (spawn_req) begin
                        if (free_found)
                            slots[free_idx] <= '{valid: 1'b1, lane: spawn_lane, y: Y_W'(SPAWN_Y)};
                        else
                            spawn_drop <= 1'b1;
                    end
                    score    <= sat_add8(score, hit_cnt);
                    miss_cnt <= sat_add8(miss_cnt, retire_cnt + ((spawn_req && !free_found) ? 1 : 0));
                    if (busy) begin
                        vld_pipe <= {vld_pipe[1:0], 1'b0};
                        if (vld_pipe[2]) begin
                            if (pat_addr == PW'(PAT_LEN - 1)) consumed <= 1'b1;
                            else                              pat_addr <= pat_addr + 1'b1;
                        end
                    end else if (beat_tick && !consumed) begin
                        pat_lat  <= pat_data;
                        vld_pipe <= 3'b001;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_note_scheduler.sv
// Randomised and directed bench for note_scheduler against a slot-list reference model.
module tb_note_scheduler;
    localparam int NS = 8, PL = 8, HIT_Y = 440, HIT_WIN = 20, BOT = 479;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, pause = 1'b0;
    logic       move_tick = 1'b0, beat_tick = 1'b0;
    logic [2:0] pat_data, pat_addr, hit_btn = '0, rd_idx = '0;
    logic       rd_valid, spawn_drop, busy;
    logic [1:0] rd_lane, state;
    logic [9:0] rd_y;
    logic [7:0] score, miss_cnt;
    logic [2:0] pat_mem [PL];

    int n_chk = 0, n_err = 0, drop_seen = 0;
    bit rs_lvl = 0, st_lvl = 0, pa_lvl = 0;

    // reference model: per-slot records plus a queue of pending lane examinations
    int m_valid [NS], m_lane [NS], m_y [NS];
    int m_state = 0, m_score = 0, m_miss = 0, m_done = 0, m_drop = 0;
    int pend [$];

    assign pat_data = pat_mem[pat_addr];
    always #20 clk = ~clk;

    note_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .move_tick(move_tick), .beat_tick(beat_tick), .pat_data(pat_data),
        .pat_addr(pat_addr), .hit_btn(hit_btn), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_lane(rd_lane), .rd_y(rd_y), .score(score),
        .miss_cnt(miss_cnt), .spawn_drop(spawn_drop), .state(state), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin m_valid[s] = 0; m_lane[s] = 0; m_y[s] = 0; end
        m_score = 0; m_miss = 0; m_done = 0; m_drop = 0;
        pend.delete();
    endtask

    task automatic model_step(input bit rs, st, pa, mv, bt, input logic [2:0] hb);
        int hit [NS];
        int anyv, busy_pre, nxt, fr, nhit, nmiss, code, d;
        logic [2:0] e;
        if (!rs) begin clear_model(); m_state = 0; return; end
        m_drop = 0;
        busy_pre = (pend.size() != 0);
        anyv = 0;
        for (int s = 0; s < NS; s++) anyv |= m_valid[s];
        case (m_state)
            0: if (st) begin clear_model(); m_state = 1; end
            1: begin
                nxt = 1;
                if (pa && !busy_pre) nxt = 2;
                else if (m_done == PL && !anyv && !busy_pre) nxt = 3;
                for (int s = 0; s < NS; s++) hit[s] = 0;
                for (int l = 0; l < 3; l++) begin
                    if (hb[2-l]) begin
                        for (int s = 0; s < NS; s++) begin
                            d = m_y[s] - HIT_Y;
                            if (m_valid[s] && m_lane[s] == l && d >= -HIT_WIN && d <= HIT_WIN) begin
                                hit[s] = 1;
                                break;
                            end
                        end
                    end
                end
                fr = -1;
                for (int s = NS - 1; s >= 0; s--) if (!m_valid[s]) fr = s;
                nhit = 0; nmiss = 0;
                for (int s = 0; s < NS; s++) begin
                    if (hit[s]) begin m_valid[s] = 0; nhit++; end
                    else if (mv && m_valid[s]) begin
                        if (m_y[s] == BOT) begin m_valid[s] = 0; nmiss++; end
                        else m_y[s]++;
                    end
                end
                if (busy_pre) begin
                    code = pend.pop_front();
                    if ((code & 3) != 3) begin
                        if (fr >= 0) begin m_valid[fr] = 1; m_lane[fr] = code & 3; m_y[fr] = 0; end
                        else begin m_drop = 1; nmiss++; end
                    end
                    if (code >= 4) m_done++;
                end else if (bt && m_done < PL) begin
                    e = pat_mem[m_done];
                    for (int l = 0; l < 3; l++) pend.push_back((e[2-l] ? l : 3) + (l == 2 ? 4 : 0));
                end
                m_score = (m_score + nhit > 255) ? 255 : m_score + nhit;
                m_miss  = (m_miss + nmiss > 255) ? 255 : m_miss + nmiss;
                m_state = nxt;
            end
            2: if (!pa) m_state = 1;
            default: if (!st) m_state = 0;
        endcase
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("busy", busy, int'(pend.size() != 0));
        chk("score", score, m_score);
        chk("miss_cnt", miss_cnt, m_miss);
        chk("spawn_drop", spawn_drop, m_drop);
        chk("pat_addr", pat_addr, (m_done < PL) ? m_done : PL - 1);
        drop_seen += int'(spawn_drop);
        for (int i = 0; i < NS; i++) begin
            rd_idx = 3'(i);
            #1;
            chk($sformatf("rd_valid[%0d]", i), rd_valid, m_valid[i]);
            if (m_valid[i]) begin
                chk($sformatf("rd_lane[%0d]", i), rd_lane, m_lane[i]);
                chk($sformatf("rd_y[%0d]", i), rd_y, m_y[i]);
            end
        end
    endtask

    task automatic cyc(input bit mv, input bit bt, input logic [2:0] hb);
        @(negedge clk);
        reset = rs_lvl; start = st_lvl; pause = pa_lvl;
        move_tick = mv; beat_tick = bt; hit_btn = hb;
        model_step(rs_lvl, st_lvl, pa_lvl, mv, bt, hb);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic chk_slot(input int i, input int v, input int ln, input int y);
        rd_idx = 3'(i);
        #1;
        chk($sformatf("slot%0d_valid", i), rd_valid, v);
        chk($sformatf("slot%0d_lane", i), rd_lane, ln);
        chk($sformatf("slot%0d_y", i), rd_y, y);
    endtask

    initial begin
        int gap, cnt, hp;
        bit bt;
        logic [2:0] hb;
        pat_mem = '{3'b100, 3'b011, 3'b100, 3'b111, 3'b111, 3'b011, 3'b111, 3'b000};

        rs_lvl = 0; st_lvl = 0;
        repeat (3) cyc(0, 0, 0);
        chk("rst_state", state, 0); chk("rst_busy", busy, 0); chk("rst_score", score, 0);
        chk_slot(0, 0, 0, 0);

        rs_lvl = 1; st_lvl = 1;
        repeat (9) cyc(0, 0, 0);
        cyc(0, 1, 0); chk("busy_ph0", busy, 1);
        repeat (2) begin cyc(0, 0, 0); chk("busy_ph", busy, 1); end
        cyc(0, 0, 0); chk("busy_end", busy, 0);
        chk_slot(0, 1, 0, 0);
        cyc(0, 1, 0); repeat (4) cyc(0, 0, 0);
        chk("pat_addr2", pat_addr, 2);
        chk_slot(1, 1, 1, 0); chk_slot(2, 1, 2, 0);

        repeat (39) cyc(1, 0, 0);
        cyc(0, 1, 0); repeat (4) cyc(0, 0, 0);
        repeat (380) cyc(1, 0, 0);
        cyc(0, 0, 3'b010); chk("hit_419", score, 0);
        cyc(1, 0, 0); cyc(0, 0, 3'b100); chk("hit_420", score, 1);
        chk_slot(0, 0, 0, 420);
        repeat (40) cyc(1, 0, 0);
        cyc(0, 0, 3'b010); chk("hit_460", score, 2);
        cyc(1, 0, 0); cyc(0, 0, 3'b001); chk("hit_461", score, 2);
        repeat (18) cyc(1, 0, 0);
        cyc(1, 0, 3'b100); chk("hit_vs_move_score", score, 3); chk("retire_miss", miss_cnt, 1);

        drop_seen = 0;
        repeat (4) begin cyc(0, 1, 0); repeat (4) cyc(0, 0, 0); end
        chk("drop_pulses", drop_seen, 3); chk("drop_miss", miss_cnt, 4);
        chk_slot(7, 1, 2, 0);

        pa_lvl = 1; cyc(0, 0, 0); chk("paused", state, 2);
        repeat (20) cyc(1, 0, 3'b111);
        chk_slot(0, 1, 0, 0);
        pa_lvl = 0; cyc(0, 0, 0); chk("resumed", state, 1);

        cyc(0, 1, 0); repeat (4) cyc(0, 0, 0);
        repeat (480) cyc(1, 0, 0);
        cyc(0, 0, 0); chk("done", state, 3); chk("final_miss", miss_cnt, 12);
        st_lvl = 0; cyc(0, 0, 0); chk("to_idle", state, 0);

        for (int song = 0; song < 4; song++) begin
            for (int i = 0; i < PL; i++) pat_mem[i] = 3'($urandom_range(0, 7));
            hp = (song % 2) ? 6 : 40;
            st_lvl = 1; pa_lvl = 0; gap = 0; cnt = 0;
            cyc(0, 0, 0);
            while (m_state != 3 && cnt < 6000) begin
                if (pa_lvl) begin if ($urandom_range(0, 7) == 0) pa_lvl = 0; end
                else if ($urandom_range(0, 199) == 0) pa_lvl = 1;
                if (gap > 0) gap--;
                bt = (gap == 0) && !pa_lvl;
                if (bt) gap = $urandom_range(2, 40);
                for (int b = 0; b < 3; b++) hb[b] = ($urandom_range(0, hp - 1) == 0);
                cyc($urandom_range(0, 3) != 0, bt, hb);
                cnt++;
            end
            chk("song_done", state, 3);
            repeat (3) cyc(0, 0, 0);
            st_lvl = 0; cyc(0, 0, 0); chk("song_idle", state, 0);
        end

        st_lvl = 1; cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 0, 0);
        rs_lvl = 0; cyc(0, 0, 0);
        chk("mid_rst_state", state, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", pat_addr, 0); chk("mid_rst_miss", miss_cnt, 0);
        for (int i = 0; i < NS; i++) chk_slot(i, 0, 0, 0);
        rs_lvl = 1; cyc(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
